// File: rtl/wm_pkg.sv
// Shared constants for the washing-machine sequencer: state codes, selector
// bit positions and default phase durations.
package wm_pkg;

    localparam int unsigned ST_W    = 4;
    localparam int unsigned SEL_W   = 2;
    localparam int unsigned RINSE_W = 3;

    localparam logic [3:0] ST_IDLE       = 4'd0;
    localparam logic [3:0] ST_FILL       = 4'd1;
    localparam logic [3:0] ST_HEAT       = 4'd2;
    localparam logic [3:0] ST_WASH       = 4'd3;
    localparam logic [3:0] ST_DRAIN      = 4'd4;
    localparam logic [3:0] ST_RINSE_FILL = 4'd5;
    localparam logic [3:0] ST_RINSE      = 4'd6;
    localparam logic [3:0] ST_SPIN       = 4'd7;
    localparam logic [3:0] ST_FAULT      = 4'd8;

    localparam int unsigned SEL_HEAT_BIT = 0;
    localparam int unsigned SEL_DET_BIT  = 1;

    localparam int unsigned DEF_CNT_W        = 8;
    localparam int unsigned DEF_WASH_BASE    = 10;
    localparam int unsigned DEF_WASH_STEP    = 10;
    localparam int unsigned DEF_RINSE_PASSES = 2;
    localparam int unsigned DEF_RINSE_CYCLE  = 15;
    localparam int unsigned DEF_DRAIN_CYCLE  = 30;
    localparam int unsigned DEF_SPIN_CYCLE   = 20;
    localparam int unsigned DEF_FILL_TIMEOUT = 100;
    localparam int unsigned DEF_HEAT_TIMEOUT = 200;

endpackage

// File: rtl/wash_sequencer_if.sv
// Front-panel / sensor inputs and actuator outputs of the wash sequencer.
interface wash_sequencer_if;
    import wm_pkg::*;

    logic [SEL_W-1:0] SELECTOR;
    logic             START;
    logic             PAUSE;
    logic             ABORT;
    logic             WATER_LEVEL_SENSOR;
    logic             TEMP_SENSOR;

    logic             DOOR_LOCK;
    logic             WATER_VALVE;
    logic             DETERGENT_HATCH;
    logic             WATER_HEATER;
    logic             DRUM_MOTOR;
    logic             WATER_PUMP;
    logic             SPIN_MOTOR;
    logic             FAULT;
    logic             DONE;
    logic [ST_W-1:0]  CURRENT_STATE;

    modport master (
        output SELECTOR, START, PAUSE, ABORT, WATER_LEVEL_SENSOR, TEMP_SENSOR,
        input  DOOR_LOCK, WATER_VALVE, DETERGENT_HATCH, WATER_HEATER, DRUM_MOTOR,
               WATER_PUMP, SPIN_MOTOR, FAULT, DONE, CURRENT_STATE
    );

    modport slave (
        input  SELECTOR, START, PAUSE, ABORT, WATER_LEVEL_SENSOR, TEMP_SENSOR,
        output DOOR_LOCK, WATER_VALVE, DETERGENT_HATCH, WATER_HEATER, DRUM_MOTOR,
               WATER_PUMP, SPIN_MOTOR, FAULT, DONE, CURRENT_STATE
    );

endinterface

// File: rtl/wm_phase_timer.sv
// Loadable down-counter shared by the timed phases and the fill/heat watchdog.
module wm_phase_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             hold,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero_c
);

    logic [CNT_W-1:0] cnt_q;

    // Load wins over hold; the count saturates at zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (!hold && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/wash_sequencer.sv
// Washing-machine controller: fill, optional heat, wash, rinse passes and spin,
// with pause, abort-to-drain and fill/heat watchdog faults.
module wash_sequencer
    import wm_pkg::*;
#(
    parameter int unsigned CNT_W        = DEF_CNT_W,
    parameter int unsigned WASH_BASE    = DEF_WASH_BASE,
    parameter int unsigned WASH_STEP    = DEF_WASH_STEP,
    parameter int unsigned RINSE_PASSES = DEF_RINSE_PASSES,
    parameter int unsigned RINSE_CYCLE  = DEF_RINSE_CYCLE,
    parameter int unsigned DRAIN_CYCLE  = DEF_DRAIN_CYCLE,
    parameter int unsigned SPIN_CYCLE   = DEF_SPIN_CYCLE,
    parameter int unsigned FILL_TIMEOUT = DEF_FILL_TIMEOUT,
    parameter int unsigned HEAT_TIMEOUT = DEF_HEAT_TIMEOUT
) (
    input  logic            clk,
    input  logic            rst_n,
    wash_sequencer_if.slave bus
);

    localparam logic [CNT_W-1:0] FILL_LD  = CNT_W'(FILL_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] HEAT_LD  = CNT_W'(HEAT_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] RINSE_LD = CNT_W'(RINSE_CYCLE - 1);
    localparam logic [CNT_W-1:0] DRAIN_LD = CNT_W'(DRAIN_CYCLE - 1);
    localparam logic [CNT_W-1:0] SPIN_LD  = CNT_W'(SPIN_CYCLE - 1);

    logic [ST_W-1:0]    state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [RINSE_W-1:0] rinse_q, rinse_d;
    logic               abort_q, abort_d;
    logic               done_q, done_d;
    logic               tmr_load, tmr_hold, tmr_zero_c;
    logic [CNT_W-1:0]   tmr_val, wash_ld_c;
    logic               sensor_c, paused_c;

    assign wash_ld_c = CNT_W'(WASH_BASE + WASH_STEP * 32'(sel_q) - 1);

    wm_phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .hold     (tmr_hold),
        .load_val (tmr_val),
        .zero_c   (tmr_zero_c)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            rinse_q <= '0;
            abort_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            rinse_q <= rinse_d;
            abort_q <= abort_d;
            done_q  <= done_d;
        end
    end

    // Next state; priority is watchdog timeout, then abort, then pause, then progress.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        rinse_d  = rinse_q;
        abort_d  = abort_q;
        tmr_hold = 1'b1;
        sensor_c = (state_q == ST_HEAT) ? bus.TEMP_SENSOR : bus.WATER_LEVEL_SENSOR;
        case (state_q)
            ST_IDLE: begin
                if (bus.START) begin
                    state_d = ST_FILL;
                    sel_d   = bus.SELECTOR;
                    rinse_d = RINSE_W'(RINSE_PASSES);
                    abort_d = 1'b0;
                end
            end
            ST_FILL, ST_HEAT, ST_RINSE_FILL: begin
                if (!bus.PAUSE && tmr_zero_c && !sensor_c) begin
                    state_d = ST_FAULT;
                end else if (bus.ABORT) begin
                    state_d = ST_DRAIN;
                    abort_d = 1'b1;
                end else if (!bus.PAUSE) begin
                    if (sensor_c) begin
                        if (state_q == ST_RINSE_FILL)               state_d = ST_RINSE;
                        else if (state_q == ST_HEAT)                state_d = ST_WASH;
                        else if (sel_q[SEL_HEAT_BIT])               state_d = ST_HEAT;
                        else                                        state_d = ST_WASH;
                    end else begin
                        tmr_hold = 1'b0;
                    end
                end
            end
            ST_WASH, ST_RINSE: begin
                if (bus.ABORT) begin
                    state_d = ST_DRAIN;
                    abort_d = 1'b1;
                end else if (!bus.PAUSE) begin
                    if (tmr_zero_c) state_d  = ST_DRAIN;
                    else            tmr_hold = 1'b0;
                end
            end
            ST_DRAIN: begin
                if (!bus.PAUSE) begin
                    if (!tmr_zero_c) begin
                        tmr_hold = 1'b0;
                    end else if (abort_q) begin
                        state_d = ST_IDLE;
                        abort_d = 1'b0;
                    end else if (rinse_q != '0) begin
                        state_d = ST_RINSE_FILL;
                        rinse_d = rinse_q - RINSE_W'(1);
                    end else begin
                        state_d = ST_SPIN;
                    end
                end
            end
            ST_SPIN: begin
                if (!bus.PAUSE) begin
                    if (tmr_zero_c) state_d  = ST_IDLE;
                    else            tmr_hold = 1'b0;
                end
            end
            ST_FAULT: ;
            default: state_d = ST_IDLE;
        endcase

        done_d   = (state_q == ST_SPIN) && (state_d == ST_IDLE);
        tmr_load = (state_d != state_q);
        tmr_val  = '0;
        case (state_d)
            ST_FILL, ST_RINSE_FILL: tmr_val = FILL_LD;
            ST_HEAT:                tmr_val = HEAT_LD;
            ST_WASH:                tmr_val = wash_ld_c;
            ST_RINSE:               tmr_val = RINSE_LD;
            ST_DRAIN:               tmr_val = DRAIN_LD;
            ST_SPIN:                tmr_val = SPIN_LD;
            default:                tmr_val = '0;
        endcase
    end

    // Actuator decode from the state register; pause drops everything but the lock.
    always_comb begin
        bus.DOOR_LOCK       = 1'b0;
        bus.WATER_VALVE     = 1'b0;
        bus.DETERGENT_HATCH = 1'b0;
        bus.WATER_HEATER    = 1'b0;
        bus.DRUM_MOTOR      = 1'b0;
        bus.WATER_PUMP      = 1'b0;
        bus.SPIN_MOTOR      = 1'b0;
        bus.FAULT           = 1'b0;
        bus.DONE            = done_q;
        bus.CURRENT_STATE   = (state_q > ST_FAULT) ? ST_IDLE : state_q;
        paused_c = bus.PAUSE && (state_q >= ST_FILL) && (state_q <= ST_SPIN);
        case (state_q)
            ST_FILL: begin
                bus.DOOR_LOCK       = 1'b1;
                bus.WATER_VALVE     = 1'b1;
                bus.DETERGENT_HATCH = sel_q[SEL_DET_BIT];
            end
            ST_HEAT: begin
                bus.DOOR_LOCK    = 1'b1;
                bus.WATER_HEATER = 1'b1;
            end
            ST_WASH, ST_RINSE: begin
                bus.DOOR_LOCK  = 1'b1;
                bus.DRUM_MOTOR = 1'b1;
            end
            ST_DRAIN: begin
                bus.DOOR_LOCK  = 1'b1;
                bus.WATER_PUMP = 1'b1;
            end
            ST_RINSE_FILL: begin
                bus.DOOR_LOCK   = 1'b1;
                bus.WATER_VALVE = 1'b1;
            end
            ST_SPIN: begin
                bus.DOOR_LOCK  = 1'b1;
                bus.WATER_PUMP = 1'b1;
                bus.SPIN_MOTOR = 1'b1;
            end
            ST_FAULT: begin
                bus.DOOR_LOCK  = 1'b1;
                bus.WATER_PUMP = 1'b1;
                bus.FAULT      = 1'b1;
            end
            default: ;
        endcase
        if (paused_c) begin
            bus.WATER_VALVE     = 1'b0;
            bus.DETERGENT_HATCH = 1'b0;
            bus.WATER_HEATER    = 1'b0;
            bus.DRUM_MOTOR      = 1'b0;
            bus.WATER_PUMP      = 1'b0;
            bus.SPIN_MOTOR      = 1'b0;
        end
    end

endmodule

// File: tb/tb_wash_sequencer.sv
// Directed plus randomized bench for wash_sequencer; two instances (two rinse
// passes and none) are checked every cycle against a phase-level reference model.
module tb_wash_sequencer;

    localparam int WASH_BASE = 10, WASH_STEP = 10, RINSE_CYCLE = 15;
    localparam int DRAIN_CYCLE = 30, SPIN_CYCLE = 20;
    localparam int FILL_TIMEOUT = 100, HEAT_TIMEOUT = 200;
    localparam int P_IDLE = 0, P_FILL = 1, P_HEAT = 2, P_WASH = 3, P_DRAIN = 4;
    localparam int P_RINSE_FILL = 5, P_RINSE = 6, P_SPIN = 7, P_FAULT = 8;

    logic       clk;
    logic       rst_n, start, pause, abort, level, temp;
    logic [1:0] sel;

    int checks = 0;
    int failures = 0;
    int wash_cnt = 0, spin_cnt = 0, done_cnt = 0;

    // Reference model: phase, unpaused cycles spent in it, rinses completed.
    int         m_phase  [2];
    int         m_el     [2];
    int         m_rinses [2];
    int         m_passes [2];
    logic [1:0] m_sel    [2];
    logic       m_abort  [2];
    logic       m_done   [2];

    wash_sequencer_if bus_a ();
    wash_sequencer_if bus_b ();

    assign bus_a.SELECTOR = sel;   assign bus_b.SELECTOR = sel;
    assign bus_a.START    = start; assign bus_b.START    = start;
    assign bus_a.PAUSE    = pause; assign bus_b.PAUSE    = pause;
    assign bus_a.ABORT    = abort; assign bus_b.ABORT    = abort;
    assign bus_a.WATER_LEVEL_SENSOR = level; assign bus_b.WATER_LEVEL_SENSOR = level;
    assign bus_a.TEMP_SENSOR = temp; assign bus_b.TEMP_SENSOR = temp;

    wash_sequencer #(
        .CNT_W(8), .WASH_BASE(WASH_BASE), .WASH_STEP(WASH_STEP), .RINSE_PASSES(2),
        .RINSE_CYCLE(RINSE_CYCLE), .DRAIN_CYCLE(DRAIN_CYCLE), .SPIN_CYCLE(SPIN_CYCLE),
        .FILL_TIMEOUT(FILL_TIMEOUT), .HEAT_TIMEOUT(HEAT_TIMEOUT)
    ) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));

    wash_sequencer #(
        .CNT_W(8), .WASH_BASE(WASH_BASE), .WASH_STEP(WASH_STEP), .RINSE_PASSES(0),
        .RINSE_CYCLE(RINSE_CYCLE), .DRAIN_CYCLE(DRAIN_CYCLE), .SPIN_CYCLE(SPIN_CYCLE),
        .FILL_TIMEOUT(FILL_TIMEOUT), .HEAT_TIMEOUT(HEAT_TIMEOUT)
    ) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int phase_len(input int p, input logic [1:0] s);
        case (p)
            P_FILL, P_RINSE_FILL: return FILL_TIMEOUT;
            P_HEAT:               return HEAT_TIMEOUT;
            P_WASH:               return WASH_BASE + WASH_STEP * int'(s);
            P_RINSE:              return RINSE_CYCLE;
            P_DRAIN:              return DRAIN_CYCLE;
            P_SPIN:               return SPIN_CYCLE;
            default:              return 0;
        endcase
    endfunction

    task automatic enter(input int i, input int p);
        m_phase[i] = p;
        m_el[i]    = 0;
    endtask

    task automatic model_step(input int i);
        int   p;
        logic sensor, last;
        p = m_phase[i];
        m_done[i] = 1'b0;
        sensor = (p == P_HEAT) ? temp : level;
        last   = (m_el[i] == phase_len(p, m_sel[i]) - 1);
        if (!rst_n) begin
            enter(i, P_IDLE);
            m_sel[i] = 2'b00; m_rinses[i] = 0; m_abort[i] = 1'b0;
        end else begin
            case (p)
                P_IDLE: if (start) begin
                    enter(i, P_FILL);
                    m_sel[i] = sel; m_rinses[i] = 0; m_abort[i] = 1'b0;
                end
                P_FILL, P_HEAT, P_RINSE_FILL: begin
                    if (!pause && !sensor && last) enter(i, P_FAULT);
                    else if (abort) begin enter(i, P_DRAIN); m_abort[i] = 1'b1; end
                    else if (!pause) begin
                        if (!sensor)               m_el[i]++;
                        else if (p == P_RINSE_FILL) enter(i, P_RINSE);
                        else if (p == P_FILL && m_sel[i][0]) enter(i, P_HEAT);
                        else                        enter(i, P_WASH);
                    end
                end
                P_WASH, P_RINSE: begin
                    if (abort) begin enter(i, P_DRAIN); m_abort[i] = 1'b1; end
                    else if (!pause) begin
                        if (last) enter(i, P_DRAIN); else m_el[i]++;
                    end
                end
                P_DRAIN: if (!pause) begin
                    if (!last) m_el[i]++;
                    else if (m_abort[i]) begin enter(i, P_IDLE); m_abort[i] = 1'b0; end
                    else if (m_rinses[i] < m_passes[i]) begin
                        enter(i, P_RINSE_FILL); m_rinses[i]++;
                    end else enter(i, P_SPIN);
                end
                P_SPIN: if (!pause) begin
                    if (last) begin enter(i, P_IDLE); m_done[i] = 1'b1; end
                    else m_el[i]++;
                end
                default: ;
            endcase
        end
    endtask

    // {lock, valve, hatch, heater, motor, pump, spin, fault, done}
    function automatic logic [8:0] exp_out(input int i);
        int   p;
        logic lk, vl, ht, he, mo, pu, sp, fl;
        p  = m_phase[i];
        lk = (p != P_IDLE);
        vl = (p == P_FILL) || (p == P_RINSE_FILL);
        ht = (p == P_FILL) && m_sel[i][1];
        he = (p == P_HEAT);
        mo = (p == P_WASH) || (p == P_RINSE);
        pu = (p == P_DRAIN) || (p == P_SPIN) || (p == P_FAULT);
        sp = (p == P_SPIN);
        fl = (p == P_FAULT);
        if (pause && p >= P_FILL && p <= P_SPIN) {vl, ht, he, mo, pu, sp} = 6'b0;
        return {lk, vl, ht, he, mo, pu, sp, fl, m_done[i]};
    endfunction

    task automatic check_dut(input int i, input logic [3:0] st, input logic [8:0] outs);
        logic [8:0] e;
        e = exp_out(i);
        checks++;
        assert (st === 4'(m_phase[i])) else begin
            failures++;
            $error("FAIL state[%0d] obs=%0d exp=%0d at %0t", i, st, m_phase[i], $time);
        end
        checks++;
        assert (outs === e) else begin
            failures++;
            $error("FAIL outputs[%0d] obs=%b exp=%b phase=%0d at %0t", i, outs, e, m_phase[i], $time);
        end
    endtask

    task automatic expect_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s obs=%0d exp=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        @(negedge clk);
        check_dut(0, bus_a.CURRENT_STATE, {bus_a.DOOR_LOCK, bus_a.WATER_VALVE, bus_a.DETERGENT_HATCH,
                  bus_a.WATER_HEATER, bus_a.DRUM_MOTOR, bus_a.WATER_PUMP, bus_a.SPIN_MOTOR,
                  bus_a.FAULT, bus_a.DONE});
        check_dut(1, bus_b.CURRENT_STATE, {bus_b.DOOR_LOCK, bus_b.WATER_VALVE, bus_b.DETERGENT_HATCH,
                  bus_b.WATER_HEATER, bus_b.DRUM_MOTOR, bus_b.WATER_PUMP, bus_b.SPIN_MOTOR,
                  bus_b.FAULT, bus_b.DONE});
        if (bus_a.CURRENT_STATE == 4'd3) wash_cnt++;
        if (bus_a.CURRENT_STATE == 4'd7) spin_cnt++;
        if (bus_a.DONE) done_cnt++;
    endtask

    task automatic wait_idle(input string tag, input int maxc);
        int n;
        n = 0;
        while ((m_phase[0] != P_IDLE || m_phase[1] != P_IDLE) && n < maxc) begin
            tick();
            n++;
        end
        expect_int({tag, "_idle_timeout"}, int'(n < maxc), 1);
    endtask

    task automatic wait_phase(input string tag, input int p, input int maxc);
        int n;
        n = 0;
        while (m_phase[0] != p && n < maxc) begin
            tick();
            n++;
        end
        expect_int({tag, "_phase_timeout"}, int'(n < maxc), 1);
    endtask

    initial begin
        m_passes[0] = 2;
        m_passes[1] = 0;
        for (int i = 0; i < 2; i++) begin
            m_phase[i] = P_IDLE; m_el[i] = 0; m_rinses[i] = 0;
            m_sel[i] = 2'b00; m_abort[i] = 1'b0; m_done[i] = 1'b0;
        end
        rst_n = 1'b0; start = 1'b0; pause = 1'b0; abort = 1'b0;
        level = 1'b0; temp = 1'b0; sel = 2'b00;

        // Reset
        tick(); tick();
        expect_int("reset_state", int'(bus_a.CURRENT_STATE), 0);
        rst_n = 1'b1;

        // Plain cycle, level arrives after a few cycles of fill
        wash_cnt = 0; done_cnt = 0;
        start = 1'b1; tick(); start = 1'b0;
        repeat (4) tick();
        level = 1'b1;
        wait_idle("plain", 400);
        level = 1'b0;
        tick();
        expect_int("plain_wash_cycles", wash_cnt, 10);
        expect_int("plain_done_pulses", done_cnt, 1);

        // Heat + detergent, selector changed mid-run
        wash_cnt = 0;
        sel = 2'b11; start = 1'b1; tick(); start = 1'b0; sel = 2'b00;
        repeat (2) tick();
        level = 1'b1; tick();
        expect_int("heat_entered", int'(bus_a.CURRENT_STATE), 2);
        repeat (8) tick();
        temp = 1'b1; tick(); temp = 1'b0;
        wait_idle("heat", 500);
        level = 1'b0;
        expect_int("heat_wash_cycles", wash_cnt, 40);

        // Fill watchdog
        start = 1'b1; tick(); start = 1'b0;
        repeat (99) tick();
        expect_int("fill_before_timeout", int'(bus_a.CURRENT_STATE), 1);
        tick();
        expect_int("fault_state", int'(bus_a.CURRENT_STATE), 8);
        expect_int("fault_pump_lock", int'({bus_a.WATER_PUMP, bus_a.DOOR_LOCK}), 3);
        start = 1'b1; abort = 1'b1; pause = 1'b1;
        repeat (10) tick();
        start = 1'b0; abort = 1'b0; pause = 1'b0;
        expect_int("fault_sticky", int'(bus_a.FAULT), 1);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        expect_int("fault_cleared", int'(bus_a.CURRENT_STATE), 0);

        // Pause mid-wash
        wash_cnt = 0; level = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        wait_phase("pause", P_WASH, 50);
        repeat (3) tick();
        pause = 1'b1; repeat (7) tick(); pause = 1'b0;
        wait_idle("pause", 400);
        expect_int("pause_wash_cycles", wash_cnt, 17);

        // Abort during rinse
        start = 1'b1; tick(); start = 1'b0;
        wait_phase("abort", P_RINSE, 300);
        spin_cnt = 0; done_cnt = 0;
        repeat (2) tick();
        abort = 1'b1; tick(); abort = 1'b0;
        wait_idle("abort", 400);
        expect_int("abort_no_spin", spin_cnt, 0);
        expect_int("abort_no_done", done_cnt, 0);

        // Reset during spin
        start = 1'b1; tick(); start = 1'b0;
        wait_phase("spin", P_SPIN, 400);
        repeat (4) tick();
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        expect_int("spin_reset_state", int'(bus_a.CURRENT_STATE), 0);
        expect_int("spin_reset_motor", int'({bus_a.SPIN_MOTOR, bus_a.DOOR_LOCK}), 0);
        level = 1'b0;

        // Randomized operation
        for (int c = 0; c < 2500; c++) begin
            rst_n = ($urandom_range(0, 299) != 0) && ((c % 500) != 0);
            start = ($urandom_range(0, 7) == 0);
            sel   = 2'($urandom_range(0, 3));
            pause = ($urandom_range(0, 7) == 0);
            abort = ($urandom_range(0, 39) == 0);
            level = ($urandom_range(0, 5) == 0);
            temp  = ($urandom_range(0, 5) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wash_sequencer.md
# wash_sequencer

Parametrised next-generation washing-machine controller: a Moore FSM sequencing fill, optional heat, wash, a configurable number of rinse passes, and a final spin. Adds pause, abort, fill/heat watchdog faults and a completion pulse. Sits between the front-panel selector/start logic and the actuator drivers. Sensor inputs are pre-synchronised.

## Interface
- CNT_W, 8, width of phase timer; every duration below must be ≤ 2^CNT_W−1 and ≥ 1
- WASH_BASE, 10, wash ticks for SELECTOR=0
- WASH_STEP, 10, extra wash ticks per SELECTOR increment (wash = WASH_BASE + WASH_STEP·SELECTOR)
- RINSE_PASSES, 2, rinse fill/agitate/drain passes after main drain (0 allowed, max 7)
- RINSE_CYCLE, 15, agitate ticks per rinse
- DRAIN_CYCLE, 30, ticks per drain
- SPIN_CYCLE, 20, final spin ticks
- FILL_TIMEOUT, 100, max ticks in any fill state before fault
- HEAT_TIMEOUT, 200, max ticks in heat before fault

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock, reset is synchronous and active-low
- SELECTOR  in  2  bit1 = detergent, bit0 = heating; sampled only on START acceptance
- START  in  1  level; accepted in IDLE only
- PAUSE  in  1  level; freezes sequence while high
- ABORT  in  1  level; jumps to drain-and-stop
- WATER_LEVEL_SENSOR  in  1  drum full
- TEMP_SENSOR  in  1  target temperature reached
- DOOR_LOCK, WATER_VALVE, DETERGENT_HATCH, WATER_HEATER, DRUM_MOTOR, WATER_PUMP, SPIN_MOTOR  out  1 each  actuators
- FAULT  out  1  high in FAULT state
- DONE  out  1  one-cycle pulse on normal completion
- CURRENT_STATE  out  4  state code

## Operation
- States/codes: IDLE 0, FILL 1, HEAT 2, WASH 3, DRAIN 4, RINSE_FILL 5, RINSE 6, SPIN 7, FAULT 8; codes 9–15 → IDLE next cycle, outputs as IDLE.
- IDLE: START → FILL; latch SELECTOR to sel_q, rinse_left ← RINSE_PASSES.
- FILL: valve on, hatch = sel_q[1]; level → HEAT if sel_q[0] else WASH; timeout → FAULT.
- HEAT: heater on; TEMP_SENSOR → WASH; timeout → FAULT.
- WASH: motor on for WASH_BASE+WASH_STEP·sel_q ticks → DRAIN.
- DRAIN: pump on for DRAIN_CYCLE ticks → RINSE_FILL if rinse_left≠0 (decrement on exit), else SPIN; after abort → IDLE directly, no DONE.
- RINSE_FILL: valve on, hatch off; level → RINSE; timeout → FAULT.
- RINSE: motor on RINSE_CYCLE ticks → DRAIN.
- SPIN: SPIN_MOTOR and pump on SPIN_CYCLE ticks → IDLE, DONE=1 for the single cycle SPIN→IDLE transition is registered (DONE registered, high first IDLE cycle).
- FAULT: DOOR_LOCK=1, WATER_PUMP=1, FAULT=1, others 0; leaves only via rst_n.
- DOOR_LOCK=1 in every state except IDLE; all other actuators 0 unless listed.
- PAUSE high in any timed/fill/heat state: state and timer frozen, all actuators 0 except DOOR_LOCK; watchdog frozen too. PAUSE ignored in IDLE and FAULT.
- ABORT high in FILL/HEAT/WASH/RINSE_FILL/RINSE: next state DRAIN with full DRAIN_CYCLE reload, abort flag set. Ignored in DRAIN/SPIN/IDLE/FAULT. ABORT beats PAUSE; watchdog timeout beats ABORT.
- Simultaneous sensor and timeout on same cycle: sensor wins.

## Timing
- Reset: CURRENT_STATE=IDLE, all outputs 0, timer/rinse_left/sel_q/abort flag 0.
- Outputs decoded combinationally from state register (except DONE, registered).
- Timed state of duration N lasts exactly N unpaused cycles: timer loaded N−1 on entry, exits on the cycle timer==0 and !PAUSE.
- Watchdog: timer loaded TIMEOUT−1 on entry to fill/heat; fault when it reaches 0 with condition still false, i.e. after exactly TIMEOUT unpaused cycles.
- START→FILL latency 1 cycle; sensor→next state 1 cycle.
- rst_n low mid-sequence: IDLE next edge, outputs 0 regardless of state.

## Structure
- Package wm_pkg: state code localparams (4-bit), selector bit positions, default duration constants.
- Sub-module wm_phase_timer: CNT_W loadable down-counter with load, hold and zero flag; one instance shared by timed and watchdog phases.
- Duration mux and rinse counter live in the top.

## Test plan
- SELECTOR=00, START, level at cycle 5: FILL→WASH, motor 10 cycles, drain 30, two rinse passes, spin 20, DONE pulse once, IDLE.
- SELECTOR=11: hatch high during FILL only; HEAT until TEMP_SENSOR; WASH 40 cycles; SELECTOR changed mid-run has no effect.
- Level never asserted: FAULT exactly 100 cycles after FILL entry, pump+lock high, only rst_n clears.
- PAUSE 7 cycles mid-WASH: actuators off except lock, total WASH time 10+7 cycles, remaining count preserved.
- ABORT during RINSE: DRAIN 30 cycles, then IDLE with no SPIN and no DONE.
- rst_n low during SPIN: next edge IDLE, all outputs 0; RINSE_PASSES=0 run goes DRAIN→SPIN directly.
